// File: rtl/pipeline_ctrl_pkg.sv
// ============================================================================
// Module : cpu_types_pkg
// Brief  : Latch-command and controller-state types shared by pipeline_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  typedef enum logic [1:0] {
    PIPE_RUN   = 2'd0,
    PIPE_STALL = 2'd1,
    PIPE_FLUSH = 2'd2
  } pipe_state_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } pctl_state_t;

  // $0 is hard-wired to zero, so writing it never creates a dependence.
  function automatic logic load_use_hazard(
    input logic       dren_ex,
    input logic       regwrite_ex,
    input logic [4:0] wsel_ex,
    input logic [4:0] rs_dec,
    input logic [4:0] rt_dec
  );
    return dren_ex && regwrite_ex && (wsel_ex != 5'd0) &&
           ((wsel_ex == rs_dec) || (wsel_ex == rt_dec));
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
// ============================================================================
// Module : pipeline_ctrl_if
// Brief  : Hazard inputs and latch commands of pipeline_ctrl; the counter
//          signals exist only when PIPE_PERF_CNT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  import cpu_types_pkg::*;

  logic        ihit;
  logic        dhit;
  logic        dREN_mem;
  logic        dWEN_mem;
  logic        redirect_mem;
  logic        dREN_ex;
  logic        RegWrite_ex;
  logic [4:0]  regWSEL_ex;
  logic [4:0]  rs_dec;
  logic [4:0]  rt_dec;
  logic        halt_mem;
  logic        halt_wb;
  pipe_state_t fd_state;
  pipe_state_t de_state;
  pipe_state_t em_state;
  pipe_state_t mw_state;
  logic        pc_en;
  logic        dmem_wait;
  logic        halt;
`ifdef PIPE_PERF_CNT_EN
  logic             valid_mem;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic [CNT_W-1:0] retired;
`endif

  modport master (
    input  ihit, dhit, dREN_mem, dWEN_mem, redirect_mem,
    input  dREN_ex, RegWrite_ex, regWSEL_ex, rs_dec, rt_dec,
    input  halt_mem, halt_wb,
`ifdef PIPE_PERF_CNT_EN
    input  valid_mem,
    output stall_cycles, flush_count, retired,
`endif
    output fd_state, de_state, em_state, mw_state, pc_en, dmem_wait, halt
  );

  modport slave (
    output ihit, dhit, dREN_mem, dWEN_mem, redirect_mem,
    output dREN_ex, RegWrite_ex, regWSEL_ex, rs_dec, rt_dec,
    output halt_mem, halt_wb,
`ifdef PIPE_PERF_CNT_EN
    output valid_mem,
    input  stall_cycles, flush_count, retired,
`endif
    input  fd_state, de_state, em_state, mw_state, pc_en, dmem_wait, halt
  );

endinterface

`default_nettype wire

// File: rtl/pipeline_ctrl_perf_counters.sv
// ============================================================================
// Module : pipe_perf_counters
// Brief  : Saturating stall / flush / retire counters, frozen while halted.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             halted,
  input  logic             stall_evt,
  input  logic             flush_evt,
  input  logic             retire_evt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] retired
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cycles <= '0;
      flush_count  <= '0;
      retired      <= '0;
    end else if (!halted) begin
      if (stall_evt && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_evt && (flush_count  != '1)) flush_count  <= flush_count  + CNT_W'(1);
      if (retire_evt && (retired     != '1)) retired      <= retired      + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module : pipeline_ctrl
// Brief  : Hazard/latch controller for the 5-stage core (sticky halt, dcache
//          wait tracking). Optional counters under PIPE_PERF_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic           CLK,
  input  logic           RST,
  pipeline_ctrl_if.master bus
);

  pctl_state_t state;
  logic        halt_r;
  logic        dwait_r;
  logic        mem_busy;
  logic        load_use;
  logic        redirect_taken;
  pipe_state_t fd, de, em, mw;
  logic        pc_en;

  assign mem_busy = (bus.dREN_mem | bus.dWEN_mem) & ~bus.dhit;
  assign load_use = load_use_hazard(bus.dREN_ex, bus.RegWrite_ex, bus.regWSEL_ex,
                                    bus.rs_dec, bus.rt_dec);

  // First match wins; a redirect waiting behind a dcache miss is applied on dhit.
  always_comb begin
    fd = PIPE_RUN;  de = PIPE_RUN;  em = PIPE_RUN;  mw = PIPE_RUN;
    pc_en = 1'b1;
    redirect_taken = 1'b0;
    if (RST) begin
      fd = PIPE_FLUSH; de = PIPE_FLUSH; em = PIPE_FLUSH; mw = PIPE_FLUSH;
      pc_en = 1'b0;
    end else if ((state == HALTED) || mem_busy) begin
      fd = PIPE_STALL; de = PIPE_STALL; em = PIPE_STALL; mw = PIPE_STALL;
      pc_en = 1'b0;
    end else if (bus.redirect_mem) begin
      fd = PIPE_FLUSH; de = PIPE_FLUSH; em = PIPE_FLUSH;
      redirect_taken = 1'b1;
    end else if (load_use) begin
      fd = PIPE_STALL; de = PIPE_FLUSH;
      pc_en = 1'b0;
    end else if (bus.halt_mem) begin
      fd = PIPE_FLUSH; de = PIPE_FLUSH;
      pc_en = 1'b0;
    end else if (!bus.ihit) begin
      fd = PIPE_FLUSH;
      pc_en = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= RUN;
      halt_r  <= 1'b0;
      dwait_r <= 1'b0;
    end else if (bus.halt_wb) begin
      state   <= HALTED;
      halt_r  <= 1'b1;
      dwait_r <= 1'b0;
    end else begin
      case (state)
        RUN: if (mem_busy) begin
          state   <= DWAIT;
          dwait_r <= 1'b1;
        end
        DWAIT: if (bus.dhit) begin
          state   <= RUN;
          dwait_r <= 1'b0;
        end
        HALTED: state <= HALTED;
        default: begin
          state   <= RUN;
          halt_r  <= 1'b0;
          dwait_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fd_state  = fd;
  assign bus.de_state  = de;
  assign bus.em_state  = em;
  assign bus.mw_state  = mw;
  assign bus.pc_en     = pc_en;
  assign bus.halt      = halt_r;
  assign bus.dmem_wait = dwait_r;

`ifdef PIPE_PERF_CNT_EN
  pipe_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .CLK          (CLK),
    .RST          (RST),
    .halted       (state == HALTED),
    .stall_evt    (~pc_en),
    .flush_evt    (redirect_taken),
    .retire_evt   ((mw == PIPE_RUN) & bus.valid_mem),
    .stall_cycles (bus.stall_cycles),
    .flush_count  (bus.flush_count),
    .retired      (bus.retired)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module : tb_pipeline_ctrl
// Brief  : Directed vector table plus multi-cycle sequences for pipeline_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;
  import cpu_types_pkg::*;

  localparam int CNT_W = 4;

  logic CLK = 1'b0;
  logic RST;
  int   tests = 0;
  int   fails = 0;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        ihit, dhit, dren_m, dwen_m, redir, dren_ex, rw_ex;
    logic [4:0]  wsel, rs, rt;
    logic        halt_mem;
    pipe_state_t fd, de, em, mw;
    logic        pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic ih, logic dh, logic drm, logic dwm,
                              logic rd, logic dre, logic rwe, logic [4:0] ws,
                              logic [4:0] rs, logic [4:0] rt, logic hm,
                              pipe_state_t f, pipe_state_t d, pipe_state_t e,
                              pipe_state_t m, logic p);
    vec_t v;
    v.name = n; v.ihit = ih; v.dhit = dh; v.dren_m = drm; v.dwen_m = dwm;
    v.redir = rd; v.dren_ex = dre; v.rw_ex = rwe; v.wsel = ws; v.rs = rs;
    v.rt = rt; v.halt_mem = hm; v.fd = f; v.de = d; v.em = e; v.mw = m; v.pc = p;
    return v;
  endfunction

  task automatic idle();
    bus.ihit = 1'b1; bus.dhit = 1'b0; bus.dREN_mem = 1'b0; bus.dWEN_mem = 1'b0;
    bus.redirect_mem = 1'b0; bus.dREN_ex = 1'b0; bus.RegWrite_ex = 1'b0;
    bus.regWSEL_ex = 5'd0; bus.rs_dec = 5'd0; bus.rt_dec = 5'd0;
    bus.halt_mem = 1'b0; bus.halt_wb = 1'b0;
`ifdef PIPE_PERF_CNT_EN
    bus.valid_mem = 1'b0;
`endif
  endtask

  task automatic check_outs(string n, pipe_state_t f, pipe_state_t d,
                            pipe_state_t e, pipe_state_t m, logic p);
    logic [8:0] act, exp;
    act = {bus.fd_state, bus.de_state, bus.em_state, bus.mw_state, bus.pc_en};
    exp = {f, d, e, m, p};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: fd/de/em/mw/pc_en got %0d/%0d/%0d/%0d/%0b want %0d/%0d/%0d/%0d/%0b",
               n, act[8:7], act[6:5], act[4:3], act[2:1], act[0],
               exp[8:7], exp[6:5], exp[4:3], exp[2:1], exp[0]);
    end
  endtask

  task automatic check_val(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  task automatic next_neg();
    @(negedge CLK);
  endtask

  initial begin
    idle();
    RST = 1'b1;
    vecs.push_back(mk("idle",          1,0,0,0,0,0,0, 0, 0, 0,0, PIPE_RUN,  PIPE_RUN,  PIPE_RUN,  PIPE_RUN,  1));
    vecs.push_back(mk("imiss",         0,0,0,0,0,0,0, 0, 0, 0,0, PIPE_FLUSH,PIPE_RUN,  PIPE_RUN,  PIPE_RUN,  0));
    vecs.push_back(mk("load_busy",     1,0,1,0,0,0,0, 0, 0, 0,0, PIPE_STALL,PIPE_STALL,PIPE_STALL,PIPE_STALL,0));
    vecs.push_back(mk("store_busy",    1,0,0,1,0,0,0, 0, 0, 0,0, PIPE_STALL,PIPE_STALL,PIPE_STALL,PIPE_STALL,0));
    vecs.push_back(mk("load_hit",      1,1,1,0,0,0,0, 0, 0, 0,0, PIPE_RUN,  PIPE_RUN,  PIPE_RUN,  PIPE_RUN,  1));
    vecs.push_back(mk("redir_imiss",   0,0,0,0,1,0,0, 0, 0, 0,0, PIPE_FLUSH,PIPE_FLUSH,PIPE_FLUSH,PIPE_RUN,  1));
    vecs.push_back(mk("lu_rs",         1,0,0,0,0,1,1, 8, 8, 0,0, PIPE_STALL,PIPE_FLUSH,PIPE_RUN,  PIPE_RUN,  0));
    vecs.push_back(mk("lu_rt",         1,0,0,0,0,1,1, 9, 3, 9,0, PIPE_STALL,PIPE_FLUSH,PIPE_RUN,  PIPE_RUN,  0));
    vecs.push_back(mk("lu_r0",         1,0,0,0,0,1,1, 0, 0, 0,0, PIPE_RUN,  PIPE_RUN,  PIPE_RUN,  PIPE_RUN,  1));
    vecs.push_back(mk("lu_nowrite",    1,0,0,0,0,1,0, 8, 8, 0,0, PIPE_RUN,  PIPE_RUN,  PIPE_RUN,  PIPE_RUN,  1));
    vecs.push_back(mk("lu_notload",    1,0,0,0,0,0,1, 8, 8, 0,0, PIPE_RUN,  PIPE_RUN,  PIPE_RUN,  PIPE_RUN,  1));
    vecs.push_back(mk("lu_nomatch",    1,0,0,0,0,1,1, 8, 7, 6,0, PIPE_RUN,  PIPE_RUN,  PIPE_RUN,  PIPE_RUN,  1));
    vecs.push_back(mk("redir_lu",      1,0,0,0,1,1,1, 8, 8, 0,0, PIPE_FLUSH,PIPE_FLUSH,PIPE_FLUSH,PIPE_RUN,  1));
    vecs.push_back(mk("redir_busy",    1,0,1,0,1,0,0, 0, 0, 0,0, PIPE_STALL,PIPE_STALL,PIPE_STALL,PIPE_STALL,0));
    vecs.push_back(mk("halt_mem",      1,0,0,0,0,0,0, 0, 0, 0,1, PIPE_FLUSH,PIPE_FLUSH,PIPE_RUN,  PIPE_RUN,  0));
    vecs.push_back(mk("halt_mem_miss", 0,0,0,0,0,0,0, 0, 0, 0,1, PIPE_FLUSH,PIPE_FLUSH,PIPE_RUN,  PIPE_RUN,  0));
    vecs.push_back(mk("lu_halt_mem",   1,0,0,0,0,1,1, 5, 0, 5,1, PIPE_STALL,PIPE_FLUSH,PIPE_RUN,  PIPE_RUN,  0));
    vecs.push_back(mk("lu_imiss",      0,0,0,0,0,1,1, 5, 5, 0,0, PIPE_STALL,PIPE_FLUSH,PIPE_RUN,  PIPE_RUN,  0));

    // Reset overrides active inputs.
    repeat (2) next_neg();
    bus.redirect_mem = 1'b1;
    #1;
    check_outs("reset_outs", PIPE_FLUSH, PIPE_FLUSH, PIPE_FLUSH, PIPE_FLUSH, 1'b0);
    check_val("reset_halt", 32'(bus.halt), 0);
    check_val("reset_dwait", 32'(bus.dmem_wait), 0);
`ifdef PIPE_PERF_CNT_EN
    check_val("reset_stall_cnt", 32'(bus.stall_cycles), 0);
`endif
    idle();
    next_neg();
    RST = 1'b0;

    // Inputs return to idle before each rising edge, so the FSM stays in RUN.
    foreach (vecs[i]) begin
      bus.ihit = vecs[i].ihit;     bus.dhit = vecs[i].dhit;
      bus.dREN_mem = vecs[i].dren_m; bus.dWEN_mem = vecs[i].dwen_m;
      bus.redirect_mem = vecs[i].redir;
      bus.dREN_ex = vecs[i].dren_ex; bus.RegWrite_ex = vecs[i].rw_ex;
      bus.regWSEL_ex = vecs[i].wsel; bus.rs_dec = vecs[i].rs; bus.rt_dec = vecs[i].rt;
      bus.halt_mem = vecs[i].halt_mem;
      #1;
      check_outs(vecs[i].name, vecs[i].fd, vecs[i].de, vecs[i].em, vecs[i].mw, vecs[i].pc);
      #1;
      idle();
      next_neg();
    end

    // Load-use lasts one cycle: the load then moves on to memory.
    bus.dREN_ex = 1; bus.RegWrite_ex = 1; bus.regWSEL_ex = 5'd8; bus.rs_dec = 5'd8;
    #1 check_outs("lu_seq_c0", PIPE_STALL, PIPE_FLUSH, PIPE_RUN, PIPE_RUN, 1'b0);
    next_neg();
    bus.dREN_ex = 0; bus.RegWrite_ex = 0; bus.regWSEL_ex = 5'd0;
    bus.dREN_mem = 1; bus.dhit = 1;
    #1 check_outs("lu_seq_c1", PIPE_RUN, PIPE_RUN, PIPE_RUN, PIPE_RUN, 1'b1);
    idle();
    next_neg();

    // Dcache wait: three stalled cycles, release on dhit.
    bus.dREN_mem = 1; bus.dhit = 0;
    for (int c = 0; c < 3; c++) begin
      #1 check_outs($sformatf("dwait_stall%0d", c), PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL, 1'b0);
      check_val($sformatf("dwait_flag%0d", c), 32'(bus.dmem_wait), (c == 0) ? 0 : 1);
      next_neg();
    end
    bus.dhit = 1;
    #1 check_outs("dwait_hit", PIPE_RUN, PIPE_RUN, PIPE_RUN, PIPE_RUN, 1'b1);
    check_val("dwait_flag_hit", 32'(bus.dmem_wait), 1);
    next_neg();
    idle();
    #1 check_val("dwait_flag_after", 32'(bus.dmem_wait), 0);
    next_neg();

    // Redirect held behind a dcache wait.
    bus.redirect_mem = 1; bus.dREN_mem = 1; bus.dhit = 0;
    for (int c = 0; c < 2; c++) begin
      #1 check_outs($sformatf("redir_wait%0d", c), PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL, 1'b0);
      next_neg();
    end
    bus.dhit = 1;
    #1 check_outs("redir_wait_hit", PIPE_FLUSH, PIPE_FLUSH, PIPE_FLUSH, PIPE_RUN, 1'b1);
    next_neg();
    idle();
    next_neg();

    // Reset aborts a wait in progress.
    bus.dREN_mem = 1;
    next_neg();
    #1 check_val("rst_dwait_pre", 32'(bus.dmem_wait), 1);
    RST = 1;
    next_neg();
    #1 check_val("rst_dwait_post", 32'(bus.dmem_wait), 0);
    RST = 0;
    idle();
    next_neg();

    // Halt sequence: sticky until reset.
    bus.halt_mem = 1;
    #1 check_outs("halt_mem_seq", PIPE_FLUSH, PIPE_FLUSH, PIPE_RUN, PIPE_RUN, 1'b0);
    next_neg();
    bus.halt_mem = 0; bus.halt_wb = 1;
    #1 check_val("halt_not_yet", 32'(bus.halt), 0);
    next_neg();
    idle();
    bus.redirect_mem = 1; bus.ihit = 0;
    for (int c = 0; c < 3; c++) begin
      #1 check_outs($sformatf("halted%0d", c), PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL, 1'b0);
      check_val($sformatf("halt_flag%0d", c), 32'(bus.halt), 1);
      next_neg();
    end
    RST = 1;
    #1 check_outs("halt_rst", PIPE_FLUSH, PIPE_FLUSH, PIPE_FLUSH, PIPE_FLUSH, 1'b0);
    next_neg();
    RST = 0;
    idle();
    #1 check_val("halt_cleared", 32'(bus.halt), 0);
    check_outs("run_after_halt", PIPE_RUN, PIPE_RUN, PIPE_RUN, PIPE_RUN, 1'b1);
    next_neg();

`ifdef PIPE_PERF_CNT_EN
    RST = 1; next_neg(); RST = 0; idle();
    bus.ihit = 0;
    repeat (3) next_neg();
    bus.ihit = 1; bus.redirect_mem = 1;
    next_neg();
    idle();
    #1 check_val("perf_stall3", 32'(bus.stall_cycles), 3);
    check_val("perf_flush1", 32'(bus.flush_count), 1);
    check_val("perf_retired0", 32'(bus.retired), 0);
    bus.valid_mem = 1; bus.ihit = 0;
    repeat (20) next_neg();
    idle();
    #1 check_val("perf_stall_sat", 32'(bus.stall_cycles), 15);
    check_val("perf_retired_sat", 32'(bus.retired), 15);
    RST = 1; next_neg(); RST = 0; idle();
    bus.valid_mem = 1; bus.halt_wb = 1;
    next_neg();
    bus.halt_wb = 0; bus.ihit = 0;
    repeat (5) next_neg();
    #1 check_val("perf_frozen_ret", 32'(bus.retired), 1);
    check_val("perf_frozen_stall", 32'(bus.stall_cycles), 0);
    RST = 1; next_neg(); RST = 0; idle();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
